// File: rtl/sprite_fetch_ctrl.sv
// sprite_fetch_ctrl
// Display-side (port A) read sequencer for the shared sprite-position RAM.
// Once per frame it reads the six position words into a shadow bank. It then
// commits them to the outputs on a single edge, so the renderer never sees a
// frame that is only partly updated.
module sprite_fetch_ctrl #(
    parameter int                    WIDTH      = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 6000,
    parameter int                    STRIDE     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [WIDTH-1:0]      mem_q,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mx,
    output logic [WIDTH-1:0]      my,
    output logic [WIDTH-1:0]      p1x,
    output logic [WIDTH-1:0]      p1y,
    output logic [WIDTH-1:0]      p2x,
    output logic [WIDTH-1:0]      p2y,
    output logic                  busy,
    output logic                  done,
    output logic                  missed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [2:0]            LAST_IDX  = 3'd5;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRIDE);

    state_t                r_state;
    state_t                w_nextState;
    logic [2:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_capValid;
    logic [2:0]            r_capIdx;
    logic [WIDTH-1:0]      r_shadow [6];
    logic [WIDTH-1:0]      r_out    [6];
    logic                  r_done;
    logic                  r_missed;

    logic                  w_accept;
    logic                  w_fetching;
    logic                  w_lastFetch;
    logic                  w_commit;
    logic                  w_busy;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the decoded control strobes used by the datapath.
    always_comb begin
        w_nextState = r_state;
        w_busy      = (r_state != IDLE);
        w_accept    = 1'b0;
        w_fetching  = 1'b0;
        w_lastFetch = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start && enable) begin
                    w_accept    = 1'b1;
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                w_fetching = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_lastFetch = 1'b1;
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_nextState = COMMIT;
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Word index and address generation; the address advances one stride per
    // fetch cycle and simply holds once the last word has been addressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= 3'd0;
            r_addr <= BASE_ADDR;
        end else if (w_accept) begin
            r_idx  <= 3'd0;
            r_addr <= BASE_ADDR;
        end else if (w_fetching && !w_lastFetch) begin
            r_idx  <= r_idx + 3'd1;
            r_addr <= r_addr + ADDR_STEP;
        end else if (w_fetching) begin
            r_idx  <= 3'd0;
        end
    end

    // Capture tag trails the fetch index by one cycle to match RAM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capValid <= 1'b0;
            r_capIdx   <= 3'd0;
        end else begin
            r_capValid <= w_fetching;
            r_capIdx   <= r_idx;
        end
    end

    // Shadow bank: each returning word lands in its slot as it arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (r_capValid) begin
            for (int k = 0; k < 6; k++) begin
                if (r_capIdx == 3'(k)) begin
                    r_shadow[k] <= mem_q;
                end
            end
        end
    end

    // Visible positions change only on the commit edge, all six together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                r_out[k] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < 6; k++) begin
                r_out[k] <= r_shadow[k];
            end
        end
    end

    // Single-cycle status pulses: commit finished, or a frame start was dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_done   <= w_commit;
            r_missed <= frame_start && w_busy;
        end
    end

    assign mem_addr = r_addr;
    assign mx       = r_out[0];
    assign my       = r_out[1];
    assign p1x      = r_out[2];
    assign p1y      = r_out[3];
    assign p2x      = r_out[4];
    assign p2y      = r_out[5];
    assign busy     = w_busy;
    assign done     = r_done;
    assign missed   = r_missed;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Testbench for sprite_fetch_ctrl: two instances (normal base and a base that
// wraps the address space) run side by side against a frame-level reference
// model that works in terms of "edges since the frame was accepted".
module tb_sprite_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        frameStart;

    logic [15:0] memQ0, memQ1;
    logic [15:0] memAddr0, memAddr1;
    logic [15:0] mx0, my0, p1x0, p1y0, p2x0, p2y0;
    logic [15:0] mx1, my1, p1x1, p1y1, p2x1, p2y1;
    logic        busy0, done0, missed0;
    logic        busy1, done1, missed1;

    logic [15:0] ram [0:65535];

    int checks = 0;
    int errors = 0;

    // Reference model state, per instance
    int          mD      [2];
    logic [15:0] mAddr   [2];
    logic [15:0] mOut    [2][6];
    logic [15:0] mSnap   [2][6];
    logic        mDone   [2];
    logic        mMissed [2];
    bit          wasBusy;

    logic [15:0] dOut  [2][6];
    logic [15:0] dAddr [2];
    logic        dBusy [2];
    logic        dDone [2];
    logic        dMiss [2];

    logic [15:0] wrapTbl [6];

    sprite_fetch_ctrl dut0 (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frameStart),
        .mem_q(memQ0), .mem_addr(memAddr0),
        .mx(mx0), .my(my0), .p1x(p1x0), .p1y(p1y0), .p2x(p2x0), .p2y(p2y0),
        .busy(busy0), .done(done0), .missed(missed0)
    );

    sprite_fetch_ctrl #(.BASE_ADDR(16'hFFF8), .STRIDE(4)) dutWrap (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frameStart),
        .mem_q(memQ1), .mem_addr(memAddr1),
        .mx(mx1), .my(my1), .p1x(p1x1), .p1y(p1y1), .p2x(p2x1), .p2y(p2y1),
        .busy(busy1), .done(done1), .missed(missed1)
    );

    assign dOut[0][0] = mx0;  assign dOut[0][1] = my0;
    assign dOut[0][2] = p1x0; assign dOut[0][3] = p1y0;
    assign dOut[0][4] = p2x0; assign dOut[0][5] = p2y0;
    assign dOut[1][0] = mx1;  assign dOut[1][1] = my1;
    assign dOut[1][2] = p1x1; assign dOut[1][3] = p1y1;
    assign dOut[1][4] = p2x1; assign dOut[1][5] = p2y1;
    assign dAddr[0] = memAddr0; assign dAddr[1] = memAddr1;
    assign dBusy[0] = busy0;    assign dBusy[1] = busy1;
    assign dDone[0] = done0;    assign dDone[1] = done1;
    assign dMiss[0] = missed0;  assign dMiss[1] = missed1;

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM read port, one cycle of latency, one port per instance
    always @(posedge clk) begin
        memQ0 <= ram[memAddr0];
        memQ1 <= ram[memAddr1];
    end

    function automatic logic [15:0] baseOf(input int i);
        return (i == 0) ? 16'd6000 : 16'hFFF8;
    endfunction

    function automatic logic [15:0] wordAddr(input int i, input int k);
        return baseOf(i) + 16'(4 * k);
    endfunction

    // Frame-level model: a frame accepted at edge E0 is addressed over E0..E5,
    // commits its snapshot at E8, and any frame start seen while busy is dropped.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mD[i]      = -1;
                mAddr[i]   = baseOf(i);
                mDone[i]   = 1'b0;
                mMissed[i] = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    mOut[i][k]  = 16'd0;
                    mSnap[i][k] = 16'd0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                wasBusy    = (mD[i] >= 0);
                mDone[i]   = 1'b0;
                mMissed[i] = 1'b0;
                if (wasBusy) begin
                    mD[i] = mD[i] + 1;
                    if (mD[i] == 8) begin
                        for (int k = 0; k < 6; k++) mOut[i][k] = mSnap[i][k];
                        mDone[i] = 1'b1;
                        mD[i]    = -1;
                    end else if (mD[i] <= 5) begin
                        mAddr[i] = wordAddr(i, mD[i]);
                    end
                end
                if (frameStart && wasBusy) begin
                    mMissed[i] = 1'b1;
                end else if (frameStart && enable) begin
                    mD[i]    = 0;
                    mAddr[i] = baseOf(i);
                    for (int k = 0; k < 6; k++) mSnap[i][k] = ram[wordAddr(i, k)];
                end
            end
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output of both instances against the model
    task automatic checkAll();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("busy%0d", i),   32'(dBusy[i]), 32'(mD[i] >= 0));
            checkOutput($sformatf("done%0d", i),   32'(dDone[i]), 32'(mDone[i]));
            checkOutput($sformatf("missed%0d", i), 32'(dMiss[i]), 32'(mMissed[i]));
            checkOutput($sformatf("addr%0d", i),   32'(dAddr[i]), 32'(mAddr[i]));
            for (int k = 0; k < 6; k++) begin
                checkOutput($sformatf("pos%0d_%0d", i, k),
                            32'(dOut[i][k]), 32'(mOut[i][k]));
            end
        end
    endtask

    // Advance one clock and check on the falling edge
    task automatic applyStimulus();
        @(negedge clk);
        checkAll();
    endtask

    task automatic loadWords(input logic [15:0] first, input logic [15:0] step);
        for (int k = 0; k < 6; k++) begin
            ram[wordAddr(0, k)] = first + 16'(k) * step;
            ram[wordAddr(1, k)] = 16'h8000 + first + 16'(k) * step;
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        frameStart = 1'b0;
        wrapTbl[0] = 16'hFFF8; wrapTbl[1] = 16'hFFFC; wrapTbl[2] = 16'h0000;
        wrapTbl[3] = 16'h0004; wrapTbl[4] = 16'h0008; wrapTbl[5] = 16'h000C;
        loadWords(16'd10, 16'd10);

        applyStimulus();
        applyStimulus();
        checkOutput("resetAddr", 32'(memAddr0), 32'd6000);
        checkOutput("resetBusy", 32'(busy0), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        applyStimulus();

        // Basic fetch with known words, plus the wrapping instance's addresses
        frameStart = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            applyStimulus();
            frameStart = 1'b0;
            if (c < 6) begin
                checkOutput("fetchAddr", 32'(memAddr0), 32'(16'd6000 + 16'(4 * c)));
                checkOutput("wrapAddr",  32'(memAddr1), 32'(wrapTbl[c]));
            end
            if (c < 8) begin
                checkOutput("holdMx", 32'(mx0), 32'd0);
                checkOutput("noDone", 32'(done0), 32'd0);
            end
            if (c == 8) begin
                checkOutput("doneE8", 32'(done0), 32'd1);
                checkOutput("mx",  32'(mx0),  32'd10);
                checkOutput("my",  32'(my0),  32'd20);
                checkOutput("p1x", 32'(p1x0), 32'd30);
                checkOutput("p1y", 32'(p1y0), 32'd40);
                checkOutput("p2x", 32'(p2x0), 32'd50);
                checkOutput("p2y", 32'(p2y0), 32'd60);
            end
            if (c == 9) checkOutput("donePulse", 32'(done0), 32'd0);
        end

        // Second frame start at E3 is dropped; completion stays at E8
        loadWords(16'd100, 16'd1);
        frameStart = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            applyStimulus();
            frameStart = (c == 2);
            if (c == 3) checkOutput("missedE3", 32'(missed0), 32'd1);
            if (c == 4) checkOutput("missedPulse", 32'(missed0), 32'd0);
            if (c == 7) checkOutput("mxBeforeE8", 32'(mx0), 32'd10);
            if (c == 8) begin
                checkOutput("doneNoRestart", 32'(done0), 32'd1);
                checkOutput("mxNew", 32'(mx0), 32'd100);
                checkOutput("p2yNew", 32'(p2y0), 32'd105);
            end
            if (c == 9) checkOutput("busyAfter", 32'(busy0), 32'd0);
        end

        // Reset at E4 aborts the sequence immediately
        loadWords(16'd500, 16'd3);
        frameStart = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            applyStimulus();
            frameStart = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("rstBusy", 32'(busy0), 32'd0);
        checkOutput("rstMx",   32'(mx0),   32'd0);
        checkOutput("rstP2y",  32'(p2y0),  32'd0);
        checkOutput("rstAddr", 32'(memAddr0), 32'd6000);
        applyStimulus();
        reset = 1'b0;
        applyStimulus();
        frameStart = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            applyStimulus();
            frameStart = 1'b0;
            if (c == 8) begin
                checkOutput("cleanMx",  32'(mx0),  32'd500);
                checkOutput("cleanP2y", 32'(p2y0), 32'd515);
            end
        end

        // Frame start with enable low is ignored silently
        enable     = 1'b0;
        frameStart = 1'b1;
        applyStimulus();
        frameStart = 1'b0;
        checkOutput("disBusy",   32'(busy0),   32'd0);
        applyStimulus();
        checkOutput("disMissed", 32'(missed0), 32'd0);
        checkOutput("disMx",     32'(mx0),     32'd500);
        enable = 1'b1;

        // Randomized traffic, including enable drops and occasional resets
        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            if (mD[0] < 0 && mD[1] < 0 && $urandom_range(0, 3) == 0) begin
                loadWords(16'($urandom()), 16'($urandom_range(1, 999)));
            end
            frameStart = ($urandom_range(0, 6) == 0);
            enable     = ($urandom_range(0, 4) != 0);
            reset      = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
